mio_int_ctrl: RTL and testbench

//  Parametrised vectored interrupt controller for the multi-cycle MIPS SoC; replaces the single raw INT pin.

---
 rtl/soc_int_pkg.sv | 27 ++
 rtl/mio_int_ctrl_if.sv | 22 ++
 rtl/mio_int_ctrl_prio_enc.sv | 19 +
 rtl/mio_int_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mio_int_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/soc_int_pkg.sv
// Shared definitions for the MIO interrupt controller: FSM encoding,
// register offsets and CAUSE/STATUS bit positions.
package soc_int_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } int_state_e;

    localparam logic [1:0] ADDR_PENDING = 2'd0;
    localparam logic [1:0] ADDR_ENABLE  = 2'd1;
    localparam logic [1:0] ADDR_CAUSE   = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    localparam int CAUSE_VALID_BIT = 31;
    localparam int STATUS_GIE_BIT  = 0;
    localparam int STATUS_INT_BIT  = 1;

    // Handler address for a channel; 32-bit arithmetic wraps naturally.
    function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                             input logic [31:0] stride,
                                             input logic [4:0]  id);
        return base + 32'(id) * stride;
    endfunction

endpackage

// File: rtl/mio_int_ctrl_if.sv
// MIO register bus plus the CPU interrupt handshake for mio_int_ctrl.
interface mio_int_ctrl_if;
    logic        cs;
    logic        mem_w;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        INT;
    logic [31:0] int_vector;
    logic        int_ack;
    logic        eret;

    modport master (
        output cs, mem_w, addr, wdata, int_ack, eret,
        input  rdata, INT, int_vector
    );

    modport slave (
        input  cs, mem_w, addr, wdata, int_ack, eret,
        output rdata, INT, int_vector
    );
endinterface

// File: rtl/mio_int_ctrl_prio_enc.sv
// Combinational priority encoder: lowest set index wins.
module prio_enc_lsb #(
    parameter int N = 8
) (
    input  logic [N-1:0] req,
    output logic [4:0]   id,
    output logic         any
);

    always_comb begin
        id = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) id = 5'(i);
        end
    end

    assign any = |req;

endmodule

// File: rtl/mio_int_ctrl.sv
// Vectored interrupt controller: synchronises irq lines, latches pending
// bits, arbitrates by fixed priority and runs the INT/ack/eret handshake.
//
//  state   | meaning
//  IDLE    | no request presented; arbitrate eligible channels
//  REQ     | INT=1 with frozen id/vector, waiting for int_ack
//  SERVICE | CPU in handler; new requests only recorded, no nesting
module mio_int_ctrl
    import soc_int_pkg::*;
#(
    parameter int                N_IRQ       = 8,
    parameter logic [N_IRQ-1:0]  EDGE_MASK   = {N_IRQ{1'b1}},
    parameter int                SYNC_STAGES = 2,
    parameter logic [31:0]       VEC_BASE    = 32'h0000_0100,
    parameter logic [31:0]       VEC_STRIDE  = 32'd8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq_in,
    mio_int_ctrl_if.slave    bus
);

    logic [N_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [N_IRQ-1:0] irq_s;
    logic [N_IRQ-1:0] irq_prev_q;
    logic [N_IRQ-1:0] irq_rise;
    logic [N_IRQ-1:0] pending_q;
    logic [N_IRQ-1:0] pending_d;
    logic [N_IRQ-1:0] enable_q;
    logic [N_IRQ-1:0] req;
    logic [N_IRQ-1:0] id_oh;
    logic             gie_q;
    logic             wr_en;
    logic             id_live;

    int_state_e  state_q, state_d;
    logic [4:0]  id_q, id_d;
    logic [4:0]  cause_id_q, cause_id_d;
    logic [4:0]  win_id;
    logic        win_any;
    logic        int_q, int_d;
    logic [31:0] vec_q, vec_d;
    logic        unused_wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            irq_prev_q <= '0;
        end else begin
            sync_q[0] <= irq_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            irq_prev_q <= irq_s;
        end
    end

    assign irq_s    = sync_q[SYNC_STAGES-1];
    assign irq_rise = irq_s & ~irq_prev_q;
    assign wr_en    = bus.cs & bus.mem_w;
    assign id_oh    = N_IRQ'(1) << id_q;

    // Edge bits: set beats any clear in the same cycle. Level bits simply follow the line.
    always_comb begin
        logic [N_IRQ-1:0] clr;
        clr = '0;
        if (wr_en && bus.addr == ADDR_PENDING) clr = bus.wdata[N_IRQ-1:0];
        if (state_q == REQ && bus.int_ack) clr = clr | id_oh;
        pending_d = (EDGE_MASK & ((pending_q & ~clr) | irq_rise))
                  | (~EDGE_MASK & irq_s);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
            enable_q  <= '0;
            gie_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            if (wr_en && bus.addr == ADDR_ENABLE) enable_q <= bus.wdata[N_IRQ-1:0];
            if (wr_en && bus.addr == ADDR_STATUS) gie_q <= bus.wdata[STATUS_GIE_BIT];
        end
    end

    assign req     = pending_q & enable_q & {N_IRQ{gie_q}};
    assign id_live = |(req & id_oh);

    prio_enc_lsb #(.N(N_IRQ)) u_prio (
        .req (req),
        .id  (win_id),
        .any (win_any)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            id_q       <= '0;
            cause_id_q <= '0;
            int_q      <= 1'b0;
            vec_q      <= VEC_BASE;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            cause_id_q <= cause_id_d;
            int_q      <= int_d;
            vec_q      <= vec_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        cause_id_d = cause_id_q;
        int_d      = int_q;
        vec_d      = vec_q;
        case (state_q)
            IDLE: begin
                if (win_any) begin
                    state_d = REQ;
                    id_d    = win_id;
                    int_d   = 1'b1;
                    vec_d   = vec_addr(VEC_BASE, VEC_STRIDE, win_id);
                end
            end
            REQ: begin
                // Ack takes precedence over a withdrawal seen in the same cycle.
                if (bus.int_ack) begin
                    state_d    = SERVICE;
                    int_d      = 1'b0;
                    cause_id_d = id_q;
                end else if (!id_live) begin
                    state_d = IDLE;
                    int_d   = 1'b0;
                end
            end
            SERVICE: begin
                if (bus.eret) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                int_d   = 1'b0;
            end
        endcase
    end

    always_comb begin
        bus.rdata = '0;
        case (bus.addr)
            ADDR_PENDING: bus.rdata = 32'(pending_q);
            ADDR_ENABLE:  bus.rdata = 32'(enable_q);
            ADDR_CAUSE: begin
                bus.rdata[CAUSE_VALID_BIT] = (state_q == SERVICE);
                bus.rdata[4:0]             = cause_id_q;
            end
            default: begin
                bus.rdata[STATUS_GIE_BIT] = gie_q;
                bus.rdata[STATUS_INT_BIT] = int_q;
            end
        endcase
    end

    assign bus.INT        = int_q;
    assign bus.int_vector = vec_q;
    assign unused_wdata   = ^bus.wdata;

endmodule

// File: tb/tb_mio_int_ctrl.sv
// Self-checking bench for mio_int_ctrl: register table, directed corner
// sequences, then randomized traffic against a behavioural model.
module tb_mio_int_ctrl;

    localparam int          N     = 8;
    localparam int          S     = 2;
    localparam logic [7:0]  EMASK = 8'hF7;
    localparam logic [31:0] VB    = 32'h0000_0100;
    localparam logic [31:0] VS    = 32'd8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] irq_in = '0;
    logic [7:0] emask_v = EMASK;

    mio_int_ctrl_if bus();

    mio_int_ctrl #(
        .N_IRQ       (N),
        .EDGE_MASK   (EMASK),
        .SYNC_STAGES (S),
        .VEC_BASE    (VB),
        .VEC_STRIDE  (VS)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .irq_in (irq_in),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // ---------------- behavioural reference model ----------------
    logic [7:0]  m_line [0:S];   // [0..S-1] resynchronised line delay, [S] previous synced value
    logic [7:0]  m_pend, m_en;
    logic        m_gie;
    bit          m_presenting, m_servicing;
    int          m_cur, m_cause;
    logic [31:0] m_vec;

    task automatic model_reset();
        for (int i = 0; i <= S; i++) m_line[i] = '0;
        m_pend = '0; m_en = '0; m_gie = 1'b0;
        m_presenting = 0; m_servicing = 0;
        m_cur = 0; m_cause = 0; m_vec = VB;
    endtask

    task automatic model_step();
        logic [7:0] synced, rise, eligible, clear, lowest;
        bit wr;
        if (reset) begin
            model_reset();
            return;
        end
        synced   = m_line[S-1];
        rise     = synced & ~m_line[S];
        eligible = m_pend & m_en & (m_gie ? 8'hFF : 8'h00);
        wr       = bus.cs && bus.mem_w;
        clear    = (wr && bus.addr == 2'd0) ? bus.wdata[7:0] : 8'h00;
        if (m_presenting) begin
            if (bus.int_ack) begin
                m_presenting = 0;
                m_servicing  = 1;
                m_cause      = m_cur;
                clear        = clear | (8'd1 << m_cur);
            end else if (((eligible >> m_cur) & 8'd1) == 8'd0) begin
                m_presenting = 0;
            end
        end else if (m_servicing) begin
            if (bus.eret) m_servicing = 0;
        end else if (eligible != 8'd0) begin
            lowest       = eligible & (~eligible + 8'd1);
            m_cur        = $countones(8'(lowest - 8'd1));
            m_presenting = 1;
            m_vec        = VB + 32'(m_cur) * VS;
        end
        m_pend = (emask_v & ((m_pend & ~clear) | rise)) | (~emask_v & synced);
        if (wr && bus.addr == 2'd1) m_en  = bus.wdata[7:0];
        if (wr && bus.addr == 2'd3) m_gie = bus.wdata[0];
        for (int i = S; i > 0; i--) m_line[i] = m_line[i-1];
        m_line[0] = irq_in;
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return {24'd0, m_pend};
            2'd1:    return {24'd0, m_en};
            2'd2:    return {m_servicing, 26'd0, 5'(m_cause)};
            default: return {30'd0, m_presenting, m_gie};
        endcase
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.cs = 1'b0; bus.mem_w = 1'b0; bus.addr = 2'd0; bus.wdata = '0;
        bus.int_ack = 1'b0; bus.eret = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; irq_in = '0; idle_bus();
        cycle(); cycle();
        reset = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.cs = 1'b1; bus.mem_w = 1'b1; bus.addr = a; bus.wdata = d;
        cycle();
        bus.cs = 1'b0; bus.mem_w = 1'b0; bus.wdata = '0;
    endtask

    task automatic chk_reg(input string name, input logic [1:0] a, input logic [31:0] exp);
        bus.addr = a;
        #1;
        check(name, bus.rdata, exp);
    endtask

    task automatic pulse_ack();
        bus.int_ack = 1'b1; cycle(); bus.int_ack = 1'b0;
    endtask

    task automatic pulse_eret();
        bus.eret = 1'b1; cycle(); bus.eret = 1'b0;
    endtask

    task automatic wait_int(input string name, input logic val, input int maxc);
        int n = 0;
        while (bus.INT !== val && n < maxc) begin
            cycle();
            n++;
        end
        check(name, 32'(bus.INT), 32'(val));
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  a;
        logic [31:0] d;
        logic [1:0]  ra;
        logic [31:0] exp;
    } reg_vec_t;

    reg_vec_t tbl [8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int seen;
        idle_bus();
        model_reset();

        // reset state
        do_reset();
        check("rst_int", 32'(bus.INT), 32'd0);
        check("rst_vec", bus.int_vector, 32'h100);
        chk_reg("rst_pending", 2'd0, 32'd0);
        chk_reg("rst_enable",  2'd1, 32'd0);
        chk_reg("rst_cause",   2'd2, 32'd0);
        chk_reg("rst_status",  2'd3, 32'd0);

        // register access table
        tbl[0] = '{1'b1, 2'd1, 32'hFFFF_FFFF, 2'd1, 32'h0000_00FF};
        tbl[1] = '{1'b1, 2'd1, 32'h0000_00A5, 2'd1, 32'h0000_00A5};
        tbl[2] = '{1'b1, 2'd3, 32'hFFFF_FFFF, 2'd3, 32'h0000_0001};
        tbl[3] = '{1'b1, 2'd2, 32'hFFFF_FFFF, 2'd2, 32'h0000_0000};
        tbl[4] = '{1'b1, 2'd0, 32'h0000_00FF, 2'd0, 32'h0000_0000};
        tbl[5] = '{1'b0, 2'd0, 32'h0000_0000, 2'd1, 32'h0000_00A5};
        tbl[6] = '{1'b1, 2'd3, 32'h0000_0002, 2'd3, 32'h0000_0000};
        tbl[7] = '{1'b1, 2'd1, 32'hFFFF_FF00, 2'd1, 32'h0000_0000};
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].wr) wr(tbl[i].a, tbl[i].d);
            else cycle();
            chk_reg($sformatf("tbl_%0d", i), tbl[i].ra, tbl[i].exp);
        end

        // 1: basic edge latency, ack clears pending
        do_reset();
        wr(2'd1, 32'h01); wr(2'd3, 32'h1);
        irq_in[0] = 1'b1;
        cycle(); cycle(); cycle();
        check("t1_lat_early", 32'(bus.INT), 32'd0);
        cycle();
        check("t1_lat", 32'(bus.INT), 32'd1);
        check("t1_vec", bus.int_vector, 32'h100);
        irq_in[0] = 1'b0;
        pulse_ack();
        check("t1_ack_int", 32'(bus.INT), 32'd0);
        chk_reg("t1_cause", 2'd2, 32'h8000_0000);
        chk_reg("t1_pend", 2'd0, 32'h0);
        pulse_eret();
        chk_reg("t1_cause_eret", 2'd2, 32'h0);

        // 2: priority, then second channel after eret
        do_reset();
        wr(2'd1, 32'hFF); wr(2'd3, 32'h1);
        irq_in = 8'h24;
        wait_int("t2_int", 1'b1, 10);
        check("t2_vec", bus.int_vector, 32'h110);
        pulse_ack();
        chk_reg("t2_cause", 2'd2, 32'h8000_0002);
        pulse_eret();
        check("t2_gap", 32'(bus.INT), 32'd0);
        cycle();
        check("t2_reint", 32'(bus.INT), 32'd1);
        check("t2_vec5", bus.int_vector, 32'h128);

        // 3: level channel withdrawal, W1C ignored on level bit
        do_reset();
        wr(2'd1, 32'h08); wr(2'd3, 32'h1);
        irq_in = 8'h08;
        wait_int("t3_int", 1'b1, 10);
        check("t3_vec", bus.int_vector, 32'h118);
        wr(2'd0, 32'h08);
        chk_reg("t3_w1c_level", 2'd0, 32'h08);
        check("t3_int_held", 32'(bus.INT), 32'd1);
        irq_in = 8'h00;
        wait_int("t3_drop", 1'b0, 10);
        chk_reg("t3_status", 2'd3, 32'h1);
        chk_reg("t3_cause", 2'd2, 32'h0);

        // 4: no nesting in SERVICE, pending recorded, served after eret
        do_reset();
        wr(2'd1, 32'hFF); wr(2'd3, 32'h1);
        irq_in = 8'h10;
        wait_int("t4_int", 1'b1, 10);
        check("t4_vec", bus.int_vector, 32'h120);
        pulse_ack();
        irq_in = 8'h12;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (bus.INT) seen++;
        end
        check("t4_no_nest", 32'(seen), 32'd0);
        chk_reg("t4_pend", 2'd0, 32'h02);
        chk_reg("t4_cause", 2'd2, 32'h8000_0004);
        pulse_eret();
        check("t4_gap", 32'(bus.INT), 32'd0);
        cycle();
        check("t4_reint", 32'(bus.INT), 32'd1);
        check("t4_vec1", bus.int_vector, 32'h108);

        // 5: edge set beats coincident W1C; ack in IDLE ignored
        do_reset();
        irq_in = 8'h40;
        cycle(); cycle();
        wr(2'd0, 32'h40);
        chk_reg("t5_set_wins", 2'd0, 32'h40);
        wr(2'd0, 32'h40);
        chk_reg("t5_w1c", 2'd0, 32'h00);
        pulse_ack();
        check("t5_ack_idle_int", 32'(bus.INT), 32'd0);
        chk_reg("t5_ack_idle_cause", 2'd2, 32'h0);

        // 6: async reset in REQ and in SERVICE
        do_reset();
        wr(2'd1, 32'h08); wr(2'd3, 32'h1);
        irq_in = 8'h08;
        wait_int("t6_int", 1'b1, 10);
        reset = 1'b1;
        #1;
        check("t6_req_int", 32'(bus.INT), 32'd0);
        chk_reg("t6_req_pend", 2'd0, 32'h0);
        chk_reg("t6_req_en", 2'd1, 32'h0);
        chk_reg("t6_req_cause", 2'd2, 32'h0);
        cycle();
        reset = 1'b0;
        wr(2'd1, 32'h08); wr(2'd3, 32'h1);
        wait_int("t6_int2", 1'b1, 10);
        pulse_ack();
        chk_reg("t6_cause3", 2'd2, 32'h8000_0003);
        reset = 1'b1;
        #1;
        check("t6_svc_int", 32'(bus.INT), 32'd0);
        chk_reg("t6_svc_cause", 2'd2, 32'h0);
        chk_reg("t6_svc_en", 2'd1, 32'h0);
        chk_reg("t6_svc_status", 2'd3, 32'h0);
        cycle();
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (bus.INT) seen++;
        end
        check("t6_no_int_after_rst", 32'(seen), 32'd0);
        wr(2'd1, 32'h08);
        check("t6_en_only", 32'(bus.INT), 32'd0);
        wr(2'd3, 32'h1);
        wait_int("t6_rearm", 1'b1, 4);

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset       = ($urandom_range(0, 499) == 0);
            irq_in      = irq_in ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            bus.int_ack = ($urandom_range(0, 3) == 0);
            bus.eret    = ($urandom_range(0, 4) == 0);
            bus.cs      = ($urandom_range(0, 3) == 0);
            bus.mem_w   = 1'($urandom_range(0, 1));
            bus.addr    = 2'($urandom_range(0, 3));
            if (bus.addr == 2'd3) bus.wdata = ($urandom_range(0, 3) != 0) ? 32'h1 : 32'h0;
            else bus.wdata = $urandom;
            cycle();
            check($sformatf("rnd_int_%0d", c), 32'(bus.INT), 32'(m_presenting));
            if (m_presenting) check($sformatf("rnd_vec_%0d", c), bus.int_vector, m_vec);
            check($sformatf("rnd_rdata_%0d", c), bus.rdata, model_read(bus.addr));
        end
        reset = 1'b0;
        idle_bus();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
